ising_run_ctrl: RTL
===================

// Module: ising_run_ctrl
// PURPOSE
//  Sequences one anneal run of an array of shorted/coupled RO spin cells.
//  - Holds the oscillator array in reset, then releases it.
//  - Lets it settle for a programmable number of cycles.
//  - Measures each spin's phase against a reference oscillator over a sampling window.
//  - Returns the spin vector through a valid/ready handshake.
//  Sits between the host/config logic and the async RO array; owns the array's ro_rstn.
// PARAMETERS
//  NUM_SPINS    8   spins (RO outputs) measured per run
//  CNT_W        16  width of run_cycles and the run counter
//  RST_CYCLES   4   cycles ro_rstn is held low before a run (>=1)
//  SW_LOG2      5   sampling window = 2**SW_LOG2 cycles
//  SYNC_STAGES  2   synchronizer depth for async RO inputs (>=2)
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous, active-high reset
//  start_i       in   1          one-cycle run request; honoured only in IDLE
//  run_cycles_i  in   CNT_W      settle time; latched on accepted start
//  busy_o        out  1          high in every state except IDLE
//  ro_rstn_o     out  1          active-low reset/enable to the RO array
//  ro_phase_i    in   NUM_SPINS  async RO outputs (sout of each spin cell)
//  ref_phase_i   in   1          async reference oscillator output
//  result_o      out  NUM_SPINS  spin vector; bit=1 means anti-phase to reference
//  result_vld_o  out  1          result valid
//  result_rdy_i  in   1          consumer ready
//  abort_i       in   1          (only with ISING_RUN_ABORT_EN) cancel current run
// BEHAVIOUR
//  Reset state: state=IDLE; busy_o=0; ro_rstn_o=0; result_o=0; result_vld_o=0; all counters=0.
//  FSM states and transitions:
//   IDLE:   start_i=1 -> latch run_cycles_i, go to HOLD.
//   HOLD:   ro_rstn_o=0 for exactly RST_CYCLES cycles -> RUN.
//   RUN:    ro_rstn_o=1; counts run_cycles cycles -> SAMPLE.
//           run_cycles=0 means HOLD goes straight to SAMPLE.
//   SAMPLE: ro_rstn_o=1; first SYNC_STAGES cycles flush the synchronizers, uncounted.
//           Then, for 2**SW_LOG2 cycles, per-spin count cnt[i] += sync(ro_phase[i]) ^ sync(ref).
//           Window end -> DONE.
//   DONE:   result_o[i] = (cnt[i] > 2**(SW_LOG2-1)); a tie resolves to 0.
//           result_vld_o=1 on DONE entry; ro_rstn_o=0.
//           Held stable until result_vld_o & result_rdy_i, then -> IDLE next cycle.
//  Latency: start at cycle 0 gives result_vld_o at cycle
//   1 + RST_CYCLES + run_cycles + SYNC_STAGES + 2**SW_LOG2.
//  Handshake rules:
//   - start_i outside IDLE is ignored, not queued; this includes the cycle DONE hands back to IDLE.
//   - result_rdy_i outside DONE is ignored.
//  Counter widths:
//   - Per-spin counters are SW_LOG2+1 bits; they saturate and never wrap.
//   - The run counter is CNT_W bits and compares against the latched value.
//  Counter clear: per-spin counters clear on HOLD entry.
//  result_o keeps the last result after the handshake, until the next DONE.
//  rst mid-run: immediately returns to IDLE with ro_rstn_o=0; any pending result is lost.
// CONFIGURATION
//  ISING_RUN_ABORT_EN defined:
//   - Adds port abort_i.
//   - abort_i=1 in HOLD/RUN/SAMPLE -> IDLE next cycle: ro_rstn_o=0, result_vld_o stays 0, result_o unchanged.
//   - abort_i has no effect in IDLE or DONE.
//   - abort_i and start_i together in IDLE: start wins.
//  ISING_RUN_ABORT_EN undefined: abort_i port absent; runs always complete.
// STRUCTURE
//  Shared header ising_ctrl_defs.vh holds:
//   - FSM state encodings (IDLE, HOLD, RUN, SAMPLE, DONE) as localparams.
//   - The default SW_LOG2 and SYNC_STAGES values, shared with the array top.
//  Sub-module phase_sync #(WIDTH, STAGES): flop-chain synchronizer.
//   Instantiated once, for the NUM_SPINS+1 bits {ref_phase_i, ro_phase_i}.
//  The FSM, run counter and per-spin window counters stay in ising_run_ctrl.
// TESTING
//  1. Reset values:
//     - Assert rst mid-cycle -> busy_o=0, ro_rstn_o=0, result_vld_o=0, result_o=0 immediately.
//  2. In-phase run (NUM_SPINS=8, RST_CYCLES=4, run_cycles=10, SW_LOG2=5):
//     - All ro_phase_i in phase with ref -> result_o=8'h00.
//     - result_vld_o rises exactly 49 cycles after start_i (1+4+10+2+32).
//  3. Anti-phase spins, same config:
//     - Spin 3 anti-phase -> result_o=8'h08.
//     - Spin 0 at a 90-degree offset (count = 16, a tie) -> bit 0 = 0.
//  4. Backpressure:
//     - result_rdy_i low for 20 cycles after valid -> result_o and result_vld_o stable.
//     - result_rdy_i high -> IDLE next cycle.
//  5. Illegal starts and zero settle time:
//     - start_i pulsed during RUN and DONE -> ignored; exactly one result produced.
//     - run_cycles=0 -> HOLD goes directly to SAMPLE; latency 39.
//  6. Abort (ISING_RUN_ABORT_EN):
//     - abort_i at run cycle 5 -> IDLE next cycle, ro_rstn_o=0, no result_vld_o.
//     - Next start completes normally.

Source files
------------

// File: rtl/ising_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ising_run_ctrl_pkg
// Brief   : Shared definitions for the Ising run controller and the array top.
//           Holds the FSM state encoding and the default sampling-window and
//           synchronizer settings.
// Revision: 1.0 - initial release
// ============================================================================
package ising_run_ctrl_pkg;

  // Run sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Defaults shared with the RO array top
  localparam int DEF_SW_LOG2     = 5;
  localparam int DEF_SYNC_STAGES = 2;

  // Width of the SAMPLE-phase counter: must hold flush + window - 1
  function automatic int samp_cnt_w(input int sync_stages, input int sw_log2);
    return $clog2(sync_stages + (1 << sw_log2)) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ising_run_ctrl_phase_sync.sv
`default_nettype none
// ============================================================================
// Module  : phase_sync
// Brief   : Multi-bit flop-chain synchronizer for free-running RO outputs.
//           Bits are synchronized independently; no cross-bit coherence is
//           implied or needed since each bit is integrated over a window.
// Revision: 1.0 - initial release
// ============================================================================
module phase_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous inputs through STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ising_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ising_run_ctrl
// Brief   : Sequences one anneal run of a coupled RO spin array: hold in
//           reset, release and settle, measure each spin's phase against a
//           reference over a sampling window, return the spin vector through
//           a valid/ready handshake.
// Config  : ISING_RUN_ABORT_EN - adds abort_i to cancel a run in progress.
// Revision: 1.0 - initial release
// ============================================================================
module ising_run_ctrl
  import ising_run_ctrl_pkg::*;
#(
  parameter int NUM_SPINS   = 8,
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 4,
  parameter int SW_LOG2     = DEF_SW_LOG2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     run_cycles_i,
  output logic                 busy_o,
  output logic                 ro_rstn_o,
  input  logic [NUM_SPINS-1:0] ro_phase_i,
  input  logic                 ref_phase_i,
  output logic [NUM_SPINS-1:0] result_o,
  output logic                 result_vld_o,
`ifdef ISING_RUN_ABORT_EN
  input  logic                 abort_i,
`endif
  input  logic                 result_rdy_i
);

  localparam int WIN    = 1 << SW_LOG2;
  localparam int SPIN_W = SW_LOG2 + 1;
  localparam int SAMP_W = samp_cnt_w(SYNC_STAGES, SW_LOG2);

  // A spin reads as anti-phase only when strictly more than half the window
  // disagreed with the reference; an exact half is a tie and reads as 0.
  localparam logic [SPIN_W-1:0] THRESH   = SPIN_W'(WIN / 2);
  localparam logic [CNT_W-1:0]  HOLD_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [SAMP_W-1:0] SAMP_ON  = SAMP_W'(SYNC_STAGES);
  localparam logic [SAMP_W-1:0] SAMP_END = SAMP_W'(SYNC_STAGES + WIN - 1);

  state_e                state_q;
  logic [CNT_W-1:0]      run_len_q;
  logic [CNT_W-1:0]      run_cnt_q;
  logic [SAMP_W-1:0]     samp_cnt_q;
  logic [SPIN_W-1:0]     spin_cnt_q [NUM_SPINS];
  logic [SPIN_W-1:0]     spin_cnt_d [NUM_SPINS];
  logic [NUM_SPINS-1:0]  result_d;

  logic [NUM_SPINS:0]    phase_sync_w;
  logic                  ref_sync;
  logic                  counting;
  logic                  abort_req;

  phase_sync #(
    .WIDTH  (NUM_SPINS + 1),
    .STAGES (SYNC_STAGES)
  ) u_phase_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({ref_phase_i, ro_phase_i}),
    .q_o (phase_sync_w)
  );

  assign ref_sync = phase_sync_w[NUM_SPINS];

  // Counting starts only once the synchronizer holds post-release samples
  assign counting = (state_q == ST_SAMPLE) && (samp_cnt_q >= SAMP_ON);

`ifdef ISING_RUN_ABORT_EN
  assign abort_req = abort_i &&
                     ((state_q == ST_HOLD) || (state_q == ST_RUN) ||
                      (state_q == ST_SAMPLE));
`else
  assign abort_req = 1'b0;
`endif

  // Next per-spin counts (saturating) and the spin decision they imply
  always_comb begin
    result_d = '0;
    for (int i = 0; i < NUM_SPINS; i++) begin
      spin_cnt_d[i] = spin_cnt_q[i];
      if (counting && (phase_sync_w[i] ^ ref_sync) && (spin_cnt_q[i] != '1)) begin
        spin_cnt_d[i] = spin_cnt_q[i] + SPIN_W'(1);
      end
      result_d[i] = (spin_cnt_d[i] > THRESH);
    end
  end

  // Run sequencer with registered outputs and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      run_len_q    <= '0;
      run_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      busy_o       <= 1'b0;
      ro_rstn_o    <= 1'b0;
      result_o     <= '0;
      result_vld_o <= 1'b0;
      for (int i = 0; i < NUM_SPINS; i++) begin
        spin_cnt_q[i] <= '0;
      end
    end else if (abort_req) begin
      // Cancelled run: back to idle with the array held, old result kept
      state_q   <= ST_IDLE;
      busy_o    <= 1'b0;
      ro_rstn_o <= 1'b0;
      run_cnt_q <= '0;
      samp_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPINS; i++) begin
        spin_cnt_q[i] <= spin_cnt_d[i];
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_HOLD;
            run_len_q  <= run_cycles_i;
            run_cnt_q  <= '0;
            samp_cnt_q <= '0;
            busy_o     <= 1'b1;
            ro_rstn_o  <= 1'b0;
            for (int i = 0; i < NUM_SPINS; i++) begin
              spin_cnt_q[i] <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (run_cnt_q == HOLD_END) begin
            run_cnt_q <= '0;
            ro_rstn_o <= 1'b1;
            state_q   <= (run_len_q == '0) ? ST_SAMPLE : ST_RUN;
          end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if ((run_cnt_q + CNT_W'(1)) == run_len_q) begin
            run_cnt_q <= '0;
            state_q   <= ST_SAMPLE;
          end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (samp_cnt_q == SAMP_END) begin
            samp_cnt_q   <= '0;
            state_q      <= ST_DONE;
            result_o     <= result_d;
            result_vld_o <= 1'b1;
            ro_rstn_o    <= 1'b0;
          end else begin
            samp_cnt_q <= samp_cnt_q + SAMP_W'(1);
          end
        end
        ST_DONE: begin
          if (result_rdy_i) begin
            state_q      <= ST_IDLE;
            result_vld_o <= 1'b0;
            busy_o       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_o       <= 1'b0;
          ro_rstn_o    <= 1'b0;
          result_vld_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
